// File: rtl/pc_gen.sv
// Fetch program-counter generator: issues fetch addresses over a valid/ready port and applies
// trap/jalr/jal/branch redirects. Optional feature macro: PC_MISALIGN_TRAP_EN.
module pc_gen #(
  parameter int              XLEN        = 16,
  parameter logic [XLEN-1:0] RESET_VEC   = '0,
  parameter int              INSTR_BYTES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            halt_i,
  input  logic            trap_en_i,
  input  logic [XLEN-1:0] trap_vec_i,
  input  logic            jalr_en_i,
  input  logic [XLEN-1:0] jalr_target_i,
  input  logic            jal_en_i,
  input  logic            branch_en_i,
  input  logic [XLEN-1:0] pc_ex_i,
  input  logic [XLEN-1:0] imm_data_i,
  output logic            fetch_valid_o,
  input  logic            fetch_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic            fetch_stale_o,
  output logic            misalign_o,
  output logic [31:0]     fetch_count_o
);

  typedef enum logic [1:0] {BOOT, RUN, IDLE, HALT} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
  logic            pend_q, pend_d;
  logic [31:0]     count_q, count_d;

  logic            handshake;
  logic            redir_any;
  logic            redir_bad;
  logic            redir_take;
  logic [XLEN-1:0] rel_tgt;
  logic [XLEN-1:0] redir_tgt;

  assign rel_tgt   = pc_ex_i + imm_data_i;
  assign redir_any = trap_en_i | jalr_en_i | jal_en_i | branch_en_i;

  always_comb begin
    redir_tgt = rel_tgt;
    if (trap_en_i)
      redir_tgt = trap_vec_i;
    else if (jalr_en_i)
      redir_tgt = jalr_target_i & ~XLEN'(1);
  end

  // Trap targets are trusted; only computed targets are screened for bit 1.
`ifdef PC_MISALIGN_TRAP_EN
  assign redir_bad = redir_any && !trap_en_i && redir_tgt[1];
`else
  assign redir_bad = 1'b0;
`endif
  assign redir_take = redir_any && !redir_bad;

  assign fetch_valid_o = (state_q == RUN);
  assign handshake     = fetch_valid_o && fetch_ready_i;
  assign fetch_stale_o = handshake && pend_q;
  assign pc_o          = pc_q;
  assign fetch_count_o = count_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    count_d    = count_q;
    case (state_q)
      BOOT: begin
        if (redir_take)
          pc_d = redir_tgt;
        if (halt_i)
          state_d = HALT;
        else if (stall_i)
          state_d = IDLE;
        else
          state_d = RUN;
      end
      RUN: begin
        if (handshake) begin
          // A redirect arriving with the handshake supersedes any older pending target.
          if (redir_take)
            pc_d = redir_tgt;
          else if (pend_q)
            pc_d = pend_tgt_q;
          else
            pc_d = pc_q + XLEN'(INSTR_BYTES);
          pend_d  = 1'b0;
          count_d = count_q + 32'd1;
          if (halt_i)
            state_d = HALT;
          else if (stall_i)
            state_d = IDLE;
          else
            state_d = RUN;
        end else if (redir_take) begin
          pend_d     = 1'b1;
          pend_tgt_d = redir_tgt;
        end
      end
      IDLE: begin
        if (redir_take)
          pc_d = redir_tgt;
        if (halt_i)
          state_d = HALT;
        else if (!stall_i)
          state_d = RUN;
      end
      HALT: begin
        if (trap_en_i) begin
          pc_d    = trap_vec_i;
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VEC;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      count_q    <= count_d;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic misalign_q;

  // HALT ignores non-trap redirects, so a bad target there is not reported either.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      misalign_q <= 1'b0;
    else
      misalign_q <= redir_bad && (state_q != HALT);
  end

  assign misalign_o = misalign_q;
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: stimulus pushes expected {pc, stale} per handshake,
// a negedge monitor pops and compares them.
module tb_pc_gen;

  localparam int XLEN = 16;

`ifdef PC_MISALIGN_TRAP_EN
  localparam logic [15:0] JALR_PC   = 16'h0084;
  localparam logic [15:0] BRANCH_PC = 16'h0098;
  localparam logic        MIS_EXP   = 1'b1;
`else
  localparam logic [15:0] JALR_PC   = 16'h0032;
  localparam logic [15:0] BRANCH_PC = 16'h0022;
  localparam logic        MIS_EXP   = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            stall_i, halt_i, trap_en_i, jalr_en_i, jal_en_i, branch_en_i;
  logic [XLEN-1:0] trap_vec_i, jalr_target_i, pc_ex_i, imm_data_i;
  logic            fetch_valid_o, fetch_ready_i, fetch_stale_o, misalign_o;
  logic [XLEN-1:0] pc_o;
  logic [31:0]     fetch_count_o;

  typedef struct {
    logic [15:0] pc;
    logic        stale;
  } exp_t;

  exp_t exp_q[$];
  int   checks_total  = 0;
  int   checks_passed = 0;

  pc_gen #(.XLEN(XLEN), .RESET_VEC(16'h0100), .INSTR_BYTES(4)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .halt_i(halt_i),
    .trap_en_i(trap_en_i), .trap_vec_i(trap_vec_i),
    .jalr_en_i(jalr_en_i), .jalr_target_i(jalr_target_i),
    .jal_en_i(jal_en_i), .branch_en_i(branch_en_i),
    .pc_ex_i(pc_ex_i), .imm_data_i(imm_data_i),
    .fetch_valid_o(fetch_valid_o), .fetch_ready_i(fetch_ready_i),
    .pc_o(pc_o), .fetch_stale_o(fetch_stale_o), .misalign_o(misalign_o),
    .fetch_count_o(fetch_count_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected)
      checks_passed++;
    else
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic ready, input logic stall, input logic halt,
                               input logic trap, input logic [15:0] tvec,
                               input logic jalr, input logic [15:0] jtgt,
                               input logic jal, input logic br,
                               input logic [15:0] pcex, input logic [15:0] imm);
    fetch_ready_i = ready;
    stall_i       = stall;
    halt_i        = halt;
    trap_en_i     = trap;
    trap_vec_i    = tvec;
    jalr_en_i     = jalr;
    jalr_target_i = jtgt;
    jal_en_i      = jal;
    branch_en_i   = br;
    pc_ex_i       = pcex;
    imm_data_i    = imm;
  endtask

  task automatic expect_fetch(input logic [15:0] pc, input logic stale);
    exp_t e;
    e.pc    = pc;
    e.stale = stale;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every accepted request must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && fetch_valid_o && fetch_ready_i) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_handshake_pc", {16'h0, pc_o}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("hs_pc", {16'h0, pc_o}, {16'h0, e.pc});
        checkOutput("hs_stale", {31'h0, fetch_stale_o}, {31'h0, e.stale});
      end
    end
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_pc", {16'h0, pc_o}, 32'h100);
    checkOutput("rst_valid", {31'h0, fetch_valid_o}, 32'h0);
    checkOutput("rst_count", fetch_count_o, 32'h0);
    checkOutput("rst_stale", {31'h0, fetch_stale_o}, 32'h0);
    checkOutput("rst_misalign", {31'h0, misalign_o}, 32'h0);
    expect_fetch(16'h0100, 0);
    expect_fetch(16'h0104, 0);
    expect_fetch(16'h0108, 0);
    rst = 1'b0;
    tick();
    checkOutput("boot_valid", {31'h0, fetch_valid_o}, 32'h1);
    checkOutput("boot_pc", {16'h0, pc_o}, 32'h100);
    tick();
    tick();
    tick();
    checkOutput("seq_count", fetch_count_o, 32'd3);
    checkOutput("seq_pc", {16'h0, pc_o}, 32'h10C);
    applyStimulus(0, 0, 0, 1, 16'h0010, 0, 0, 0, 0, 0, 0);
    expect_fetch(16'h010C, 1);
    tick();
    checkOutput("pend_hold_pc", {16'h0, pc_o}, 32'h10C);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("pend_trap_pc", {16'h0, pc_o}, 32'h10);
    checkOutput("pend_trap_count", fetch_count_o, 32'd4);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0008, 16'h0020);
    expect_fetch(16'h0010, 1);
    tick();
    checkOutput("jal_hold_pc", {16'h0, pc_o}, 32'h10);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("jal_pc", {16'h0, pc_o}, 32'h28);
    checkOutput("jal_count", fetch_count_o, 32'd5);
    applyStimulus(0, 0, 0, 0, 0, 1, 16'h0051, 0, 0, 0, 0);
    expect_fetch(16'h0028, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0030, 16'hFFF0);
    tick();
    checkOutput("newest_hold_pc", {16'h0, pc_o}, 32'h28);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("newest_wins_pc", {16'h0, pc_o}, 32'h20);
    checkOutput("newest_count", fetch_count_o, 32'd6);
    applyStimulus(1, 0, 0, 1, 16'h0080, 1, 16'h0033, 0, 1, 16'h0000, 16'h0044);
    expect_fetch(16'h0020, 0);
    tick();
    checkOutput("prio_trap_pc", {16'h0, pc_o}, 32'h80);
    checkOutput("prio_count", fetch_count_o, 32'd7);
    applyStimulus(1, 0, 0, 0, 0, 1, 16'h0033, 0, 0, 0, 0);
    expect_fetch(16'h0080, 0);
    tick();
    checkOutput("jalr_pc", {16'h0, pc_o}, {16'h0, JALR_PC});
    checkOutput("jalr_misalign", {31'h0, misalign_o}, {31'h0, MIS_EXP});
    applyStimulus(1, 0, 0, 0, 0, 1, 16'h0070, 1, 0, 16'h0000, 16'h0060);
    expect_fetch(JALR_PC, 0);
    tick();
    checkOutput("prio_jalr_pc", {16'h0, pc_o}, 32'h70);
    checkOutput("prio_jalr_count", fetch_count_o, 32'd9);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 16'hFFF0, 16'h000C);
    expect_fetch(16'h0070, 1);
    expect_fetch(16'hFFFC, 0);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("wrap_top_pc", {16'h0, pc_o}, 32'hFFFC);
    tick();
    checkOutput("wrap_pc", {16'h0, pc_o}, 32'h0);
    checkOutput("wrap_count", fetch_count_o, 32'd11);
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_fetch(16'h0000, 0);
    tick();
    checkOutput("halt_valid", {31'h0, fetch_valid_o}, 32'h0);
    checkOutput("halt_pc", {16'h0, pc_o}, 32'h4);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0000, 16'h0200);
    tick();
    checkOutput("halt_jal_ignored", {16'h0, pc_o}, 32'h4);
    checkOutput("halt_valid2", {31'h0, fetch_valid_o}, 32'h0);
    applyStimulus(1, 0, 0, 1, 16'h0040, 0, 0, 0, 0, 0, 0);
    expect_fetch(16'h0040, 0);
    tick();
    checkOutput("halt_trap_valid", {31'h0, fetch_valid_o}, 32'h1);
    checkOutput("halt_trap_pc", {16'h0, pc_o}, 32'h40);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("post_trap_pc", {16'h0, pc_o}, 32'h44);
    checkOutput("post_trap_count", fetch_count_o, 32'd13);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_fetch(16'h0044, 0);
    tick();
    checkOutput("idle_valid", {31'h0, fetch_valid_o}, 32'h0);
    checkOutput("idle_pc", {16'h0, pc_o}, 32'h48);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 1, 0, 16'h0000, 16'h0090);
    tick();
    checkOutput("idle_redirect_pc", {16'h0, pc_o}, 32'h90);
    checkOutput("idle_redirect_valid", {31'h0, fetch_valid_o}, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("resume_valid", {31'h0, fetch_valid_o}, 32'h1);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("stall_keeps_valid", {31'h0, fetch_valid_o}, 32'h1);
    checkOutput("stall_keeps_pc", {16'h0, pc_o}, 32'h90);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_fetch(16'h0090, 0);
    tick();
    checkOutput("stall_hs_valid", {31'h0, fetch_valid_o}, 32'h0);
    checkOutput("stall_hs_pc", {16'h0, pc_o}, 32'h94);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0020, 16'h0002);
    expect_fetch(16'h0094, 0);
    tick();
    checkOutput("branch22_pc", {16'h0, pc_o}, {16'h0, BRANCH_PC});
    checkOutput("branch22_misalign", {31'h0, misalign_o}, {31'h0, MIS_EXP});
    checkOutput("branch22_count", fetch_count_o, 32'd16);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("misalign_one_cycle", {31'h0, misalign_o}, 32'h0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    checkOutput("midrst_pc", {16'h0, pc_o}, 32'h100);
    checkOutput("midrst_valid", {31'h0, fetch_valid_o}, 32'h0);
    checkOutput("midrst_count", fetch_count_o, 32'h0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    repeat (3) tick();
    checkOutput("sb_drained", exp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
